// File: rtl/sc_fft_pkg.sv
// Shared parameters and helpers for the serial-commutator FFT output reorder path.
package sc_fft_pkg;

    localparam int unsigned DW    = 6;
    localparam int unsigned N     = 8;
    localparam int unsigned LOG2N = $clog2(N);
    localparam int unsigned NPAIR = N / 2;
    localparam int unsigned PW    = LOG2N - 1;

    // Reverse the LOG2N-bit index
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = idx[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_fft_reorder_bank.sv
// One N x DW frame store with two write ports and two combinational read ports.
module sc_fft_reorder_bank
    import sc_fft_pkg::*;
(
    input  logic             clk,
    input  logic             we0,
    input  logic [LOG2N-1:0] waddr0,
    input  logic [DW-1:0]    wdata0,
    input  logic             we1,
    input  logic [LOG2N-1:0] waddr1,
    input  logic [DW-1:0]    wdata1,
    input  logic [LOG2N-1:0] raddr0,
    output logic [DW-1:0]    rdata0,
    input  logic [LOG2N-1:0] raddr1,
    output logic [DW-1:0]    rdata1
);

    logic [DW-1:0] mem [N];

    // Contents are deliberately not reset; flags in the parent qualify them
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/sc_fft_reorder.sv
// Ping-pong reorder buffer: bit-reversed bin pairs in, natural-order pairs out.
// Optional SC_REORDER_ERR_EN adds a sticky sof_err flag for resyncs and overflow attempts.
module sc_fft_reorder
    import sc_fft_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sof,
    output logic [DW-1:0] out0,
    output logic [DW-1:0] out1
`ifdef SC_REORDER_ERR_EN
    ,
    output logic          sof_err
`endif
);

    logic [1:0]          full_q, full_d;
    logic                wbank_q, wbank_d, rbank_q, rbank_d;
    logic [PW-1:0]       wcnt_q, wcnt_d, rcnt_q, rcnt_d, wpair;
    logic                wr_fire, rd_fire;
    logic [LOG2N-1:0]    waddr0, waddr1, raddr0, raddr1;
    logic [1:0]          bank_we;
    logic [1:0][DW-1:0]  bank_rd0, bank_rd1;
    logic [DW-1:0]       rd0, rd1, out0_d, out1_d;
    logic                out_valid_d, out_sof_d;

    assign in_ready = !full_q[wbank_q];
    assign wr_fire  = in_valid && in_ready;
    assign rd_fire  = out_valid && out_ready;

    // A sof always restarts the frame at pair 0, dropping any partial frame
    assign wpair   = in_sof ? '0 : wcnt_q;
    assign waddr0  = bitrev({wpair, 1'b0});
    assign waddr1  = bitrev({wpair, 1'b1});
    assign bank_we = wr_fire ? (wbank_q ? 2'b10 : 2'b01) : 2'b00;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sc_fft_reorder_bank u_bank (
            .clk    (clk),
            .we0    (bank_we[b]),
            .waddr0 (waddr0),
            .wdata0 (in0),
            .we1    (bank_we[b]),
            .waddr1 (waddr1),
            .wdata1 (in1),
            .raddr0 (raddr0),
            .rdata0 (bank_rd0[b]),
            .raddr1 (raddr1),
            .rdata1 (bank_rd1[b])
        );
    end

    // Counter, bank and flag next state; write and read never touch the same bank's flag
    always_comb begin
        full_d  = full_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        if (wr_fire) begin
            if (wpair == PW'(NPAIR - 1)) begin
                full_d[wbank_q] = 1'b1;
                wcnt_d          = '0;
                wbank_d         = !wbank_q;
            end else begin
                wcnt_d = wpair + 1'b1;
            end
        end
        if (rd_fire) begin
            if (rcnt_q == PW'(NPAIR - 1)) begin
                full_d[rbank_q] = 1'b0;
                rcnt_d          = '0;
                rbank_d         = !rbank_q;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    assign raddr0 = {rcnt_d, 1'b0};
    assign raddr1 = {rcnt_d, 1'b1};

    // Next output pair, forwarding this cycle's write so a just-completed frame appears next cycle
    always_comb begin
        rd0 = bank_rd0[rbank_d];
        rd1 = bank_rd1[rbank_d];
        if (bank_we[rbank_d]) begin
            if (waddr0 == raddr0) rd0 = in0;
            if (waddr1 == raddr0) rd0 = in1;
            if (waddr0 == raddr1) rd1 = in0;
            if (waddr1 == raddr1) rd1 = in1;
        end
        out_valid_d = full_d[rbank_d];
        out_sof_d   = out_valid_d && (rcnt_d == '0);
        out0_d      = out_valid_d ? rd0 : '0;
        out1_d      = out_valid_d ? rd1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out0      <= '0;
            out1      <= '0;
        end else begin
            full_q    <= full_d;
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            out_valid <= out_valid_d;
            out_sof   <= out_sof_d;
            out0      <= out0_d;
            out1      <= out1_d;
        end
    end

`ifdef SC_REORDER_ERR_EN
    // Sticky until reset: mid-frame sof or a pair offered while the buffer is full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sof_err <= 1'b0;
        end else if ((in_valid && !in_ready) || (wr_fire && in_sof && (wcnt_q != '0))) begin
            sof_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sc_fft_reorder.sv
// Self-checking bench for sc_fft_reorder: vector table, directed corner sequences and a random run.
module tb_sc_fft_reorder;
    import sc_fft_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in0 = '0, in1 = '0;
    logic          in_ready, out_valid, out_sof;
    logic [DW-1:0] out0, out1;
`ifdef SC_REORDER_ERR_EN
    logic          sof_err;
`endif

    sc_fft_reorder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out0      (out0),
        .out1      (out1)
`ifdef SC_REORDER_ERR_EN
        ,
        .sof_err   (sof_err)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: completed frames as natural-order bins, plus the partial frame being built
    logic [DW-1:0] exp_bins[$];
    logic [DW-1:0] part[N];
    int            wk = 0;
    int            rd_idx = 0;
    logic          err_m = 1'b0;

    typedef struct {
        logic          sof;
        logic [DW-1:0] i0, i1;
        logic [DW-1:0] e0, e1;
        logic          esof;
    } vec_t;
    vec_t tbl[8];

    function automatic int rev(input int v);
        int r = 0;
        for (int i = 0; i < int'(LOG2N); i++)
            if (((v >> i) & 1) != 0) r |= 1 << (int'(LOG2N) - 1 - i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_bins.delete();
        wk = 0;
        rd_idx = 0;
        err_m = 1'b0;
    endtask

    task automatic model_check();
        int pend = exp_bins.size() / int'(N);
        chk("in_ready", 32'(in_ready), 32'(pend < 2));
        chk("out_valid", 32'(out_valid), 32'(pend > 0));
        if (pend > 0) begin
            chk("out0", 32'(out0), 32'(exp_bins[2*rd_idx]));
            chk("out1", 32'(out1), 32'(exp_bins[2*rd_idx+1]));
            chk("out_sof", 32'(out_sof), 32'(rd_idx == 0));
        end else begin
            chk("out_sof_idle", 32'(out_sof), 32'd0);
        end
`ifdef SC_REORDER_ERR_EN
        chk("sof_err", 32'(sof_err), 32'(err_m));
`endif
    endtask

    // Apply inputs for the coming edge and advance the model across that edge
    task automatic drive(input logic iv, input logic sof, input logic [DW-1:0] d0,
                         input logic [DW-1:0] d1, input logic ordy);
        int  pend = exp_bins.size() / int'(N);
        logic acc = iv && (pend < 2);
        logic rd  = (pend > 0) && ordy;
        in_valid = iv; in_sof = sof; in0 = d0; in1 = d1; out_ready = ordy;
        if (iv && pend >= 2) err_m = 1'b1;
        if (rd) begin
            rd_idx++;
            if (rd_idx == int'(NPAIR)) begin
                repeat (N) void'(exp_bins.pop_front());
                rd_idx = 0;
            end
        end
        if (acc) begin
            if (sof) begin
                if (wk != 0) err_m = 1'b1;
                wk = 0;
            end
            part[rev(2*wk)]   = d0;
            part[rev(2*wk+1)] = d1;
            wk++;
            if (wk == int'(NPAIR)) begin
                for (int i = 0; i < int'(N); i++) exp_bins.push_back(part[i]);
                wk = 0;
            end
        end
    endtask

    task automatic step(input logic iv, input logic sof, input logic [DW-1:0] d0,
                        input logic [DW-1:0] d1, input logic ordy);
        @(negedge clk);
        model_check();
        drive(iv, sof, d0, d1, ordy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out0", 32'(out0), 32'd0);
        chk("rst_out1", 32'(out1), 32'd0);
`ifdef SC_REORDER_ERR_EN
        chk("rst_sof_err", 32'(sof_err), 32'd0);
`endif
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, c, n_out;
        logic seen;
        logic [DW-1:0] base;

        // Two back-to-back frames; data equals bin number (+16 on frame 2)
        tbl[0] = '{1'b1, 6'd0,  6'd4,  6'd0,  6'd1,  1'b1};
        tbl[1] = '{1'b0, 6'd2,  6'd6,  6'd2,  6'd3,  1'b0};
        tbl[2] = '{1'b0, 6'd1,  6'd5,  6'd4,  6'd5,  1'b0};
        tbl[3] = '{1'b0, 6'd3,  6'd7,  6'd6,  6'd7,  1'b0};
        tbl[4] = '{1'b1, 6'd16, 6'd20, 6'd16, 6'd17, 1'b1};
        tbl[5] = '{1'b0, 6'd18, 6'd22, 6'd18, 6'd19, 1'b0};
        tbl[6] = '{1'b0, 6'd17, 6'd21, 6'd20, 6'd21, 1'b0};
        tbl[7] = '{1'b0, 6'd19, 6'd23, 6'd22, 6'd23, 1'b0};

        do_reset();
        repeat (5) step(1'b0, 1'b0, '0, '0, 1'b1);

        // Basic reorder and back-to-back streaming, compared against the table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            model_check();
            chk("bb_in_ready", 32'(in_ready), 32'd1);
            if (i >= 4) begin
                chk("tbl_valid", 32'(out_valid), 32'd1);
                chk("tbl_out0", 32'(out0), 32'(tbl[i-4].e0));
                chk("tbl_out1", 32'(out1), 32'(tbl[i-4].e1));
                chk("tbl_sof", 32'(out_sof), 32'(tbl[i-4].esof));
            end else begin
                chk("tbl_not_valid", 32'(out_valid), 32'd0);
            end
            if (i < 8) drive(1'b1, tbl[i].sof, tbl[i].i0, tbl[i].i1, 1'b1);
            else       drive(1'b0, 1'b0, '0, '0, 1'b1);
        end
        repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1);

        // Backpressure: three frames offered with out_ready low
        p = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            model_check();
            base = DW'(8 * (p / 4) + 24);
            drive(1'b1, (p % 4) == 0, base + DW'(rev(2*(p%4))), base + DW'(rev(2*(p%4)+1)), 1'b0);
            if (in_ready) p++;
        end
        chk("bp_accepted", 32'(p), 32'd8);
        seen = 1'b0;
        for (c = 0; c < 24; c++) begin
            @(negedge clk);
            model_check();
            if (in_ready && !seen) begin
                chk("bp_ready_delay", 32'(c), 32'd4);
                seen = 1'b1;
            end
            base = DW'(8 * (p / 4) + 24);
            drive(p < 12, (p % 4) == 0, base + DW'(rev(2*(p%4))), base + DW'(rev(2*(p%4)+1)), 1'b1);
            if (in_ready && p < 12) p++;
        end
        chk("bp_ready_seen", 32'(seen), 32'd1);
        chk("bp_all_accepted", 32'(p), 32'd12);
        repeat (12) step(1'b0, 1'b0, '0, '0, 1'b1);

        // Resync: two stray pairs, then an aligned frame
        do_reset();
        step(1'b1, 1'b1, 6'd60, 6'd61, 1'b1);
        step(1'b1, 1'b0, 6'd62, 6'd63, 1'b1);
        step(1'b1, 1'b1, 6'd40, 6'd44, 1'b1);
        step(1'b1, 1'b0, 6'd42, 6'd46, 1'b1);
        step(1'b1, 1'b0, 6'd41, 6'd45, 1'b1);
        step(1'b1, 1'b0, 6'd43, 6'd47, 1'b1);
        n_out = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            model_check();
            if (out_valid) begin
                chk("resync_out0", 32'(out0), 32'(40 + 2 * n_out));
                n_out++;
            end
            drive(1'b0, 1'b0, '0, '0, 1'b1);
        end
        chk("resync_pairs", 32'(n_out), 32'd4);
`ifdef SC_REORDER_ERR_EN
        chk("resync_sof_err", 32'(sof_err), 32'd1);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic sof;
            sof = (wk == 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 24) == 0);
            step($urandom_range(0, 3) != 0, sof, DW'($urandom), DW'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        repeat (20) step(1'b0, 1'b0, '0, '0, 1'b1);

        // Reset while a frame is waiting at the output
        for (int k = 0; k < 4; k++)
            step(1'b1, k == 0, DW'(rev(2*k) + 8), DW'(rev(2*k+1) + 8), 1'b0);
        @(negedge clk);
        model_check();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        chk("async_rst_out0", 32'(out0), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            step(1'b1, k == 0, DW'(rev(2*k) + 48), DW'(rev(2*k+1) + 48), 1'b1);
        repeat (8) step(1'b0, 1'b0, '0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
